// File: rtl/mod_add_select_2x2_pkg.sv
`default_nettype none
// ============================================================================
// mod_add_select_2x2_pkg : shared mod-arith defaults and FIFO entry layout
// Revision: 1.0
// ============================================================================
package mod_add_select_2x2_pkg;

    localparam int DEFAULT_DATA_WIDTH = 18;
    localparam int DEFAULT_MODULUS    = 177147;
    localparam int ERR_COUNT_WIDTH    = 16;

    typedef struct packed {
        logic [DEFAULT_DATA_WIDTH-1:0] data;
        logic                          err;
    } fifo_entry_t;

endpackage
`default_nettype wire

// File: rtl/mod_skid_fifo2.sv
`default_nettype none
// ============================================================================
// mod_skid_fifo2 : 2-entry FIFO with 1-bit pointers and a 0..2 occupancy count
// Revision: 1.0
// ============================================================================
module mod_skid_fifo2 #(
    parameter int WIDTH = 19
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [1:0]       o_count
);

    logic [WIDTH-1:0] r_mem [0:1];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // Gated locally so overflow and underflow cannot happen whatever the caller does.
    assign w_do_push = i_push && (r_count != 2'd2);
    assign w_do_pop  = i_pop  && (r_count != 2'd0);

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/mod_add_select_2x2.sv
`default_nettype none
// ============================================================================
// mod_add_select_2x2 : final modular-add stage; selects the reduced candidate,
//                      range-checks it and buffers {data, err} in a 2-deep FIFO
// Revision: 1.0
// ============================================================================
module mod_add_select_2x2
    import mod_add_select_2x2_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int MODULUS    = DEFAULT_MODULUS
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       sign_in,
    input  logic [DATA_WIDTH-1:0]      result_A,
    input  logic [DATA_WIDTH-1:0]      result_B,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic                       out_err,
    output logic [ERR_COUNT_WIDTH-1:0] err_count
);

    localparam logic [DATA_WIDTH-1:0]      c_MODULUS  = MODULUS[DATA_WIDTH-1:0];
    localparam logic [ERR_COUNT_WIDTH-1:0] c_ERR_MAX  = '1;

    logic [DATA_WIDTH-1:0]      w_sel;
    logic                       w_err;
    logic                       w_push;
    logic                       w_pop;
    logic [1:0]                 w_count;
    logic [DATA_WIDTH:0]        w_head;
    logic [ERR_COUNT_WIDTH-1:0] r_err_count;

    // A negative (A+CONST-MODULUS) means A+CONST is already reduced.
    assign w_sel = sign_in ? result_A : result_B;
    assign w_err = (w_sel >= c_MODULUS);

    // Ready depends only on registered occupancy, never on out_ready.
    assign in_ready  = (w_count != 2'd2);
    assign out_valid = (w_count != 2'd0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    mod_skid_fifo2 #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_data ({w_sel, w_err}),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_count)
    );

    assign out_data  = w_head[DATA_WIDTH:1];
    assign out_err   = w_head[0];
    assign err_count = r_err_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_count <= '0;
        end else if (w_push && w_err && (r_err_count != c_ERR_MAX)) begin
            r_err_count <= r_err_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mod_add_select_2x2.sv
`default_nettype none
// ============================================================================
// tb_mod_add_select_2x2 : scoreboard bench for mod_add_select_2x2
// Revision: 1.0
// ============================================================================
module tb_mod_add_select_2x2;

    localparam int DW  = 18;
    localparam int MOD = 177147;

    logic          clk       = 1'b0;
    logic          reset     = 1'b1;
    logic          in_valid  = 1'b0;
    logic          sign_in   = 1'b0;
    logic [DW-1:0] result_A  = '0;
    logic [DW-1:0] result_B  = '0;
    logic          out_ready = 1'b1;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_err;
    logic [15:0]   err_count;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          err;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests     = 0;
    int   n_fail      = 0;
    int   exp_errcnt  = 0;
    int   reset_epoch = 0;
    bit   rand_ready  = 1'b0;
    bit   ready_cmd   = 1'b1;

    mod_add_select_2x2 #(
        .DATA_WIDTH (DW),
        .MODULUS    (MOD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sign_in   (sign_in),
        .result_A  (result_A),
        .result_B  (result_B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    // Downstream ready: either commanded or random, updated 2 time units after each edge.
    always begin
        @(posedge clk);
        #2;
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_cmd;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send(input logic s, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] ed, input logic ee);
        bit acc;
        acc      = 1'b0;
        sign_in  = s;
        result_A = a;
        result_B = b;
        in_valid = 1'b1;
        for (int i = 0; i < 1000 && !acc; i++) begin
            @(negedge clk);
            acc = (in_ready === 1'b1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (acc) begin
            sb_q.push_back({ed, ee});
            if (ee && exp_errcnt < 65535) exp_errcnt++;
        end else begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: word A=%0d B=%0d never accepted", a, b);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 500 && sb_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        check("drain_empty", sb_q.size(), 0);
        check("err_count", {16'd0, err_count}, exp_errcnt);
    endtask

    // Monitor: pops the scoreboard on every output transfer and checks hold-stability.
    initial begin
        bit            hold;
        logic [DW-1:0] hd;
        logic          he;
        int            seen_epoch;
        exp_t          e;
        hold       = 1'b0;
        hd         = '0;
        he         = 1'b0;
        seen_epoch = 0;
        forever begin
            @(negedge clk);
            if (seen_epoch != reset_epoch) begin
                hold       = 1'b0;
                seen_epoch = reset_epoch;
            end
            if (hold) begin
                n_tests++;
                if (!(out_valid === 1'b1 && out_data === hd && out_err === he)) begin
                    n_fail++;
                    $display("FAIL hold: valid=%0b data=%0d err=%0b required 1/%0d/%0b",
                             out_valid, out_data, out_err, hd, he);
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                n_tests++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output: data=%0d err=%0b with nothing expected",
                             out_data, out_err);
                end else begin
                    e = sb_q.pop_front();
                    if (out_data !== e.data || out_err !== e.err) begin
                        n_fail++;
                        $display("FAIL output: data=%0d err=%0b required data=%0d err=%0b",
                                 out_data, out_err, e.data, e.err);
                    end
                end
            end
            hold = (out_valid === 1'b1) && (out_ready === 1'b0);
            hd   = out_data;
            he   = out_err;
        end
    end

    initial begin
        logic          s;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] sel;

        // Reset state (no clock edge has happened yet)
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_in_ready",  {31'd0, in_ready}, 1);
        check("rst_out_data",  {14'd0, out_data}, 0);
        check("rst_out_err",   {31'd0, out_err}, 0);
        check("rst_err_count", {16'd0, err_count}, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // select-A, with 1-cycle latency
        send(1'b1, 18'd100, 18'd85097, 18'd100, 1'b0);
        check("latency_valid", {31'd0, out_valid}, 1);
        check("latency_data",  {14'd0, out_data}, 100);
        drain();

        // select-B
        @(posedge clk);
        #1;
        send(1'b0, 18'd177150, 18'd3, 18'd3, 1'b0);
        drain();

        // Range error, then saturation
        @(posedge clk);
        #1;
        send(1'b1, 18'd177147, 18'd0, 18'd177147, 1'b1);
        drain();
        check("err_count_one", {16'd0, err_count}, 1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 70000; i++) send(1'b1, 18'd177147, 18'd5, 18'd177147, 1'b1);
        drain();
        check("err_count_sat", {16'd0, err_count}, 65535);

        // Backpressure: two accepts then full, third word held upstream
        @(posedge clk);
        #1;
        ready_cmd = 1'b0;
        @(posedge clk);
        #3;
        send(1'b1, 18'd10, 18'd0, 18'd10, 1'b0);
        send(1'b1, 18'd20, 18'd0, 18'd20, 1'b0);
        sign_in  = 1'b1;
        result_A = 18'd30;
        in_valid = 1'b1;
        @(negedge clk);
        check("bp_in_ready_full", {31'd0, in_ready}, 0);
        check("bp_head",          {14'd0, out_data}, 10);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_still_full", {31'd0, in_ready}, 0);
        @(posedge clk);
        #1;
        ready_cmd = 1'b1;
        send(1'b1, 18'd30, 18'd0, 18'd30, 1'b0);
        drain();

        // Streaming with random downstream stalls
        rand_ready = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 100; i++) begin
            s   = 1'($urandom_range(0, 1));
            a   = DW'($urandom_range(0, 262143));
            b   = DW'($urandom_range(0, 262143));
            sel = s ? a : b;
            send(s, a, b, sel, (sel >= DW'(MOD)));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rand_ready = 1'b0;
        ready_cmd  = 1'b1;
        drain();

        // Mid-operation reset with two words buffered
        @(posedge clk);
        #1;
        ready_cmd = 1'b0;
        @(posedge clk);
        #3;
        send(1'b1, 18'd200000, 18'd0, 18'd200000, 1'b1);
        send(1'b0, 18'd0, 18'd44, 18'd44, 1'b0);
        @(negedge clk);
        check("pre_rst_in_ready", {31'd0, in_ready}, 0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 0);
        check("midrst_in_ready",  {31'd0, in_ready}, 1);
        check("midrst_err_count", {16'd0, err_count}, 0);
        check("midrst_out_data",  {14'd0, out_data}, 0);
        check("midrst_out_err",   {31'd0, out_err}, 0);
        reset_epoch++;
        sb_q.delete();
        exp_errcnt = 0;
        #1;
        reset     = 1'b0;
        ready_cmd = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_rst_empty", {31'd0, out_valid}, 0);
        end
        @(posedge clk);
        #1;
        send(1'b0, 18'd1, 18'd177146, 18'd177146, 1'b0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mod_add_select_2x2.md
MOD_ADD_SELECT_2X2 -- requirements
Module: mod_add_select_2x2

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 18, which is the residue word width.
REQ-002 The module SHALL have parameter MODULUS, default 177147, which is the residue modulus and must be less than 2^DATA_WIDTH.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The module SHALL have port in_valid, input, 1 bit: the upstream stage-1 word is present.
REQ-006 The module SHALL have port in_ready, output, 1 bit: the block accepts a word this cycle.
REQ-007 The module SHALL have port sign_in, input, 1 bit: the sign of (A+CONST-MODULUS) from stage 1; 1 means negative.
REQ-008 The module SHALL have port result_A, input, DATA_WIDTH bits: the candidate A+CONST.
REQ-009 The module SHALL have port result_B, input, DATA_WIDTH bits: the candidate A+CONST-MODULUS, low bits.
REQ-010 The module SHALL have port out_valid, output, 1 bit: out_data and out_err are valid.
REQ-011 The module SHALL have port out_ready, input, 1 bit: downstream accepts the word.
REQ-012 The module SHALL have port out_data, output, DATA_WIDTH bits: the reduced residue.
REQ-013 The module SHALL have port out_err, output, 1 bit: the range-check failure flag for out_data.
REQ-014 The module SHALL have port err_count, output, 16 bits: the saturating count of words accepted with errors.

Function
REQ-015 A transfer in SHALL occur on a rising edge where in_valid=1 and in_ready=1; a transfer out SHALL occur where out_valid=1 and out_ready=1.
REQ-016 Selection SHALL be: sel = sign_in ? result_A : result_B, computed on the accepted input.
REQ-017 The range check SHALL set err=1 when sel >= MODULUS (unsigned compare), else err=0; {sel, err} are stored together.
REQ-018 Storage SHALL be a 2-entry FIFO of {sel, err}, with write pointer, read pointer and a count register in the range 0..2.
REQ-019 in_ready SHALL equal (count != 2), driven combinationally from registered count only; no path from out_ready to in_ready.
REQ-020 out_valid SHALL equal (count != 0); out_data and out_err SHALL come from the head entry, held stable while out_valid=1 and out_ready=0.
REQ-021 Latency SHALL be 1 cycle: a word accepted at edge N is presented with out_valid=1 in the cycle after edge N when the FIFO was empty.
REQ-022 Throughput SHALL be 1 word per cycle when out_ready=1 continuously.
REQ-023 A simultaneous push and pop SHALL leave count unchanged; pop at count=0 or push at count=2 SHALL be impossible by construction.
REQ-024 When full (count=2), a push is not accepted even if out_ready=1 in the same cycle, since in_ready=0; the next cycle re-opens.
REQ-025 Pointers SHALL be 1 bit and wrap 1 -> 0.
REQ-026 err_count SHALL increment by 1 on each accepted input with err=1 and saturate at 16'hFFFF.
REQ-027 err_count SHALL count at acceptance, not at output.
REQ-028 Upstream data presented while in_ready=0 SHALL be ignored; upstream holds it.

Reset
REQ-029 On reset assertion, regardless of clock, the block SHALL immediately clear count, pointers and err_count to 0.
REQ-030 Consequently, during reset out_valid=0, in_ready=1, out_data=0, out_err=0 and err_count=0.
REQ-031 FIFO storage SHALL also reset to 0.
REQ-032 Reset mid-operation SHALL discard all buffered words.
REQ-033 The first accept after reset release SHALL occur no earlier than the first rising edge with reset=0.

Structure
REQ-034 The shared mod-arith package SHALL hold the default DATA_WIDTH (18), the default MODULUS (177147), and a packed struct type for the FIFO entry {data, err}.
REQ-035 The 2-entry FIFO SHALL be one sub-module, mod_skid_fifo2, parameterised by entry width.
REQ-036 Selection, range check and err_count SHALL stay in the top module.

Verification
REQ-037 Scenario select-A: sign_in=1, result_A=100, result_B=85097, out_ready=1 -> next cycle out_data=100, out_err=0.
REQ-038 Scenario select-B: sign_in=0, result_A=177150, result_B=3 -> out_data=3, out_err=0.
REQ-039 Scenario error: sign_in=1, result_A=177147 -> out_data=177147, out_err=1, err_count=1; repeated 70000 times -> err_count=65535.
REQ-040 Scenario backpressure: out_ready=0, in_valid=1 for 3 words (10, 20, 30) -> in_ready=0 after 2 accepts; then out_ready=1 -> outputs 10, 20 in order, then 30 is accepted.
REQ-041 Scenario streaming: 100 random words, out_ready toggling randomly -> output order and values match the model, with no loss or duplication.
REQ-042 Scenario mid-operation reset: with 2 words buffered, pulse reset between edges -> out_valid=0 and err_count=0 immediately, and no buffered word emerges afterwards.
